// File: rtl/zbt_arbiter.sv
// zbt_arbiter: two-port arbiter for a single ZBT SRAM port.
// Port 0 has fixed priority; port 1 is forced a grant when starved.
module zbt_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        we0,
  input  logic [18:0] addr0,
  input  logic [35:0] wdata0,
  output logic        gnt0,
  output logic        rvalid0,
  output logic [35:0] rdata0,
  input  logic        req1,
  input  logic        we1,
  input  logic [18:0] addr1,
  input  logic [35:0] wdata1,
  output logic        gnt1,
  output logic        rvalid1,
  output logic [35:0] rdata1,
  output logic [18:0] mem_addr,
  output logic        mem_we,
  output logic [35:0] mem_wdata,
  input  logic [35:0] mem_rdata
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  localparam int TD = READ_LATENCY + 1;

  typedef enum logic {
    NORMAL,
    FORCE
  } state_t;

  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  tag_t          tags [TD];
  logic [35:0]   rdata0_q;
  logic [35:0]   rdata1_q;

  // Grant decision, starve counting and FSM next state.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_nxt = NORMAL;
    cnt_nxt   = cnt;
    if (!reset) begin
      if (state == FORCE) begin
        if (req1)      gnt1 = 1'b1;
        else if (req0) gnt0 = 1'b1;
      end else begin
        if (req0)      gnt0 = 1'b1;
        else if (req1) gnt1 = 1'b1;
      end
    end
    if (req1 && !gnt1)
      cnt_nxt = (cnt == LIM) ? cnt : cnt + 1'b1;
    else
      cnt_nxt = '0;
    if (state == NORMAL && cnt_nxt == LIM) begin
      state_nxt = FORCE;
      cnt_nxt   = '0;
    end
  end

  // FSM state and starve counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= NORMAL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Launch the winning access onto the SRAM port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else begin
      unique case (1'b1)
        gnt0: begin
          mem_addr  <= addr0;
          mem_we    <= we0;
          mem_wdata <= wdata0;
        end
        gnt1: begin
          mem_addr  <= addr1;
          mem_we    <= we1;
          mem_wdata <= wdata1;
        end
        default: mem_we <= 1'b0;
      endcase
    end
  end

  // Read tag pipeline; its tail lines up with mem_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < TD; i++) tags[i] <= '0;
    end else begin
      tags[0].valid <= (gnt0 & ~we0) | (gnt1 & ~we1);
      tags[0].port  <= gnt1;
      for (int i = 1; i < TD; i++) tags[i] <= tags[i-1];
    end
  end

  assign rvalid0 = tags[TD-1].valid & ~tags[TD-1].port;
  assign rvalid1 = tags[TD-1].valid & tags[TD-1].port;
  assign rdata0  = rvalid0 ? mem_rdata : rdata0_q;
  assign rdata1  = rvalid1 ? mem_rdata : rdata1_q;

  // Hold the last returned word per port between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (rvalid0) rdata0_q <= mem_rdata;
      if (rvalid1) rdata1_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_zbt_arbiter.sv
// tb_zbt_arbiter: directed stimulus with a read-return scoreboard.
// Includes a 2-cycle read-latency ZBT SRAM model.
module tb_zbt_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, we0, req1, we1;
  logic [18:0] addr0, addr1;
  logic [35:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [35:0] rdata0, rdata1;
  logic [18:0] mem_addr;
  logic        mem_we;
  logic [35:0] mem_wdata, mem_rdata;

  zbt_arbiter dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: data sampled at the address edge, returned 2 cycles later.
  logic [35:0] mem [logic [18:0]];
  logic [35:0] d1 = '0;
  logic [35:0] d2 = '0;

  function automatic logic [35:0] init_val(logic [18:0] a);
    return {17'h15A5A, a};
  endfunction

  always @(posedge clk) begin
    d1 <= mem.exists(mem_addr) ? mem[mem_addr] : init_val(mem_addr);
    d2 <= d1;
    if (mem_we) mem[mem_addr] = mem_wdata;
  end
  assign mem_rdata = d2;

  typedef struct {
    bit          port;
    logic [35:0] data;
    int          cyc;
  } exp_t;
  exp_t sb [$];

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  task automatic push(bit p, logic [35:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    e.cyc  = cyc + 3;
    sb.push_back(e);
  endtask

  // Monitor: every read strobe must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rvalid0 && rvalid1) begin
      chk("rvalid_overlap", 1, 0);
    end else if (rvalid0 || rvalid1) begin
      if (sb.size() == 0) begin
        chk("unexpected_rvalid", {63'd0, rvalid1}, 64'hDEAD);
      end else begin
        e = sb.pop_front();
        chk("rv_port", {63'd0, rvalid1}, {63'd0, e.port});
        chk("rv_data", rvalid1 ? rdata1 : rdata0, e.data);
        chk("rv_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 0; we0 = 0; req1 = 0; we1 = 0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    chk("drain", sb.size(), 0);
  endtask

  task automatic chk_zero(string n);
    chk({n, "_gnt"}, {gnt0, gnt1}, 0);
    chk({n, "_mem"}, {mem_we, mem_addr}, 0);
    chk({n, "_wdata"}, mem_wdata, 0);
    chk({n, "_rvalid"}, {rvalid0, rvalid1}, 0);
    chk({n, "_rdata0"}, rdata0, 0);
    chk({n, "_rdata1"}, rdata1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    idle();
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    reset = 1;
    req0 = 1; req1 = 1;
    repeat (2) tick();
    @(negedge clk);
    chk_zero("reset");
    tick();
    idle();
    reset = 0;
    tick();

    // Single read on port 1.
    req1 = 1; addr1 = 19'h00123;
    @(negedge clk);
    chk("single_gnt", {gnt0, gnt1}, 2'b01);
    push(1, init_val(19'h00123));
    tick();
    idle();
    @(negedge clk);
    chk("single_addr", mem_addr, 19'h00123);
    chk("single_we", mem_we, 0);
    drain();

    // Both ports held: port 1 forced every 9th cycle.
    req0 = 1; addr0 = 19'h00010;
    req1 = 1; addr1 = 19'h00020;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (i % 9 == 8) begin
        chk("prio_gnt", {gnt0, gnt1}, 2'b01);
        push(1, init_val(19'h00020));
      end else begin
        chk("prio_gnt", {gnt0, gnt1}, 2'b10);
        push(0, init_val(19'h00010));
      end
      tick();
    end
    idle();
    drain();

    // Interleaved reads return back to back in grant order.
    for (int i = 0; i < 4; i++) begin
      idle();
      if (i % 2 == 0) begin
        req0 = 1; addr0 = 19'(i);
      end else begin
        req1 = 1; addr1 = 19'(i);
      end
      @(negedge clk);
      chk("ilv_gnt", {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      push(i % 2 == 1, init_val(19'(i)));
      tick();
    end
    idle();
    drain();
    chk("hold_rdata0", rdata0, init_val(19'd2));
    chk("hold_rdata1", rdata1, init_val(19'd3));

    // Port 1 writes then reads the top address.
    req1 = 1; we1 = 1; addr1 = 19'h7FFFF; wdata1 = 36'hABCDE0123;
    @(negedge clk);
    chk("wr_gnt", {gnt0, gnt1}, 2'b01);
    tick();
    we1 = 0;
    @(negedge clk);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 19'h7FFFF);
    chk("wr_mem_wdata", mem_wdata, 36'hABCDE0123);
    chk("rd_gnt", {gnt0, gnt1}, 2'b01);
    push(1, 36'hABCDE0123);
    tick();
    idle();
    @(negedge clk);
    chk("rd_mem_we", mem_we, 0);
    drain();

    // Read followed by a write to the same address sees old data.
    req0 = 1; addr0 = 19'h00055;
    @(negedge clk);
    chk("raw_rd_gnt", gnt0, 1);
    push(0, init_val(19'h00055));
    tick();
    we0 = 1; wdata0 = 36'h123456789;
    @(negedge clk);
    chk("raw_wr_gnt", gnt0, 1);
    tick();
    we0 = 0;
    @(negedge clk);
    chk("raw_rd2_gnt", gnt0, 1);
    push(0, 36'h123456789);
    tick();
    idle();
    drain();

    // Reset while a read is in flight discards it.
    req0 = 1; addr0 = 19'h00044;
    @(negedge clk);
    chk("rst_rd_gnt", gnt0, 1);
    tick();
    reset = 1;
    req0 = 1; req1 = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk_zero("midrst");
      tick();
    end
    reset = 0;
    idle();
    req0 = 1; addr0 = 19'h00045;
    @(negedge clk);
    chk("post_rst_gnt", {gnt0, gnt1}, 2'b10);
    push(0, init_val(19'h00045));
    tick();
    idle();
    drain();
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
